// File: rtl/hpm_sampler.sv
// hpm_sampler: periodic sampler for the mhpmcounter3..8 performance counters.
//
// The block sits on the counter CSR port between csr_regfile and perf_counters.
// CSR-file accesses always pass straight through. In the cycles the CSR file
// leaves idle, the sampler reads each counter enabled in counter_mask_i. It
// does this once every interval_i cycles and queues {idx, value} samples in a
// FIFO for trace/debug readout.
//
// Parameters:
//   FifoDepth  sample FIFO entries (power of two, >= 2)
//   Xlen       counter port width, 32 or 64 (stands in for riscv::XLEN)
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   debug_mode_i             freezes the inter-scan wait counter
//   csr_access_i/addr/we/wdata  CSR-file side of the counter port (has priority)
//   csr_rdata_o              read data back to the CSR file (= pc_data_i)
//   pc_addr_o/we_o/data_o    perf_counters side of the port
//   pc_data_i                combinational read data from perf_counters
//   enable_i, interval_i     sampling enable and inter-scan gap in cycles
//   counter_mask_i           bit k selects mhpmcounter(3+k)
//   sample_valid_o/ready_i   FIFO head handshake
//   sample_idx_o/data_o      FIFO head contents
//   scan_done_o              one-cycle pulse after the last sample of a scan
//   overflow_o, clear_i      sticky drop flag and its clear
//
// Optional feature: define HPM_SAMPLER_DELTA_EN to emit the difference from the
// previous capture of the same counter instead of the absolute value.
module hpm_sampler #(
    parameter int unsigned FifoDepth = 8,
    parameter int unsigned Xlen      = 64
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            debug_mode_i,
    input  logic            csr_access_i,
    input  logic [11:0]     csr_addr_i,
    input  logic            csr_we_i,
    input  logic [Xlen-1:0] csr_wdata_i,
    output logic [Xlen-1:0] csr_rdata_o,
    output logic [11:0]     pc_addr_o,
    output logic            pc_we_o,
    output logic [Xlen-1:0] pc_data_o,
    input  logic [Xlen-1:0] pc_data_i,
    input  logic            enable_i,
    input  logic [31:0]     interval_i,
    input  logic [5:0]      counter_mask_i,
    output logic            sample_valid_o,
    input  logic            sample_ready_i,
    output logic [2:0]      sample_idx_o,
    output logic [63:0]     sample_data_o,
    output logic            scan_done_o,
    output logic            overflow_o,
    input  logic            clear_i
);

    localparam logic [11:0] CsrMhpmCounter3  = 12'hB03;
    localparam logic [11:0] CsrMhpmCounter3h = 12'hB83;
    localparam int unsigned PtrW             = $clog2(FifoDepth);
    localparam bit          Rv32             = (Xlen == 32);

    typedef enum logic [1:0] {StIdle, StWait, StReadLo, StReadHi} state_e;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [5:0]  pend_q, pend_d;    // counters still to be read in this scan
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
    logic        ovf_q, ovf_d;

    logic [2:0]  idx;
    logic        rd_active;
    logic [11:0] rd_addr;
    logic        stall;
    logic        cap_lo;
    logic        push;
    logic        last;
    logic [63:0] cap_val;
    logic [63:0] sample_val;

    logic [PtrW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0]    idx_mem  [FifoDepth];
    logic [63:0]   data_mem [FifoDepth];
    logic          fifo_empty, fifo_full, pop, push_ok, drop;

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            pend_q  <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        if (cap_lo) begin
            lo_d = pc_data_i[31:0];
        end
        unique case (state_q)
            StIdle: begin
                if (enable_i) begin
                    state_d = StWait;
                    cnt_d   = interval_i;
                end
            end
            StWait: begin
                if (!enable_i) begin
                    state_d = StIdle;
                end else if (!debug_mode_i) begin
                    if (cnt_q == '0) begin
                        state_d = StReadLo;
                        pend_d  = counter_mask_i;  // mask is frozen for the whole scan
                    end else begin
                        cnt_d = cnt_q - 32'd1;
                    end
                end
            end
            StReadLo: begin
                if (!stall) begin
                    if (pend_q == '0) begin
                        done_d = 1'b1;
                    end else if (Rv32) begin
                        state_d = StReadHi;
                    end else begin
                        pend_d = pend_q & ~(6'b1 << idx);
                        done_d = last;
                    end
                end
            end
            StReadHi: begin
                if (!stall) begin
                    pend_d  = pend_q & ~(6'b1 << idx);
                    state_d = StReadLo;
                    done_d  = last;
                end
            end
            default: state_d = StIdle;
        endcase
        // End of scan: re-arm the wait counter, or park if sampling was switched off.
        if (done_d) begin
            if (enable_i) begin
                state_d = StWait;
                cnt_d   = interval_i;
            end else begin
                state_d = StIdle;
            end
        end
    end

    // ---------------------------------------------------------------- outputs / datapath
    always_comb begin
        idx = 3'd0;
        for (int k = 5; k >= 0; k--) begin
            if (pend_q[k]) begin
                idx = 3'(k);
            end
        end
        stall     = csr_access_i;
        rd_active = ((state_q == StReadLo) || (state_q == StReadHi)) && (pend_q != '0);
        rd_addr   = (state_q == StReadHi) ? (CsrMhpmCounter3h + {9'd0, idx})
                                          : (CsrMhpmCounter3 + {9'd0, idx});
        cap_lo    = Rv32 && (state_q == StReadLo) && rd_active && !stall;
        push      = rd_active && !stall &&
                    (((state_q == StReadLo) && !Rv32) || (state_q == StReadHi));
        last      = (pend_q & ~(6'b1 << idx)) == '0;

        if (Rv32) begin
            cap_val = {pc_data_i[31:0], lo_q};
        end else begin
            cap_val = 64'(pc_data_i);
        end

        // The sampler only ever reads; idle cycles drive zeros.
        if (csr_access_i) begin
            pc_addr_o = csr_addr_i;
            pc_we_o   = csr_we_i;
            pc_data_o = csr_wdata_i;
        end else begin
            pc_addr_o = rd_active ? rd_addr : 12'd0;
            pc_we_o   = 1'b0;
            pc_data_o = '0;
        end
        csr_rdata_o = pc_data_i;
        scan_done_o = done_q;
    end

`ifdef HPM_SAMPLER_DELTA_EN
    logic [63:0] prev_q [6];

    // Updated on every capture, even when the FIFO drops the sample.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < 6; k++) begin
                prev_q[k] <= '0;
            end
        end else if (push) begin
            prev_q[idx] <= cap_val;
        end
    end

    assign sample_val = cap_val - prev_q[idx];
`else
    assign sample_val = cap_val;
`endif

    // ---------------------------------------------------------------- sample FIFO
    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                     (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
        pop        = !fifo_empty && sample_ready_i;
        push_ok    = push && (!fifo_full || pop);
        drop       = push && fifo_full && !pop;
        wr_ptr_d   = push_ok ? (wr_ptr_q + (PtrW+1)'(1)) : wr_ptr_q;
        rd_ptr_d   = pop ? (rd_ptr_q + (PtrW+1)'(1)) : rd_ptr_q;
        // A drop in the same cycle as clear_i wins.
        ovf_d      = (ovf_q && !clear_i) || drop;

        sample_valid_o = !fifo_empty;
        sample_idx_o   = idx_mem[rd_ptr_q[PtrW-1:0]];
        sample_data_o  = data_mem[rd_ptr_q[PtrW-1:0]];
        overflow_o     = ovf_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            idx_mem[wr_ptr_q[PtrW-1:0]]  <= idx;
            data_mem[wr_ptr_q[PtrW-1:0]] <= sample_val;
        end
    end

endmodule
